// File: rtl/disp_capture.sv
// Receive side of the 4-digit seven-segment scan: filters the scanned digit bus,
// commits one digit per stable dwell and publishes a full frame once all four are seen.
module disp_capture #(
   parameter int unsigned STABLE_CYC  = 4,
   parameter int unsigned TIMEOUT_CYC = 65535
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  Hex,
   input  logic        p,
   input  logic        LE,
   input  logic [3:0]  AN,
   output logic [15:0] Hexs,
   output logic [3:0]  point,
   output logic [3:0]  LES,
   output logic        frame_valid,
   output logic        an_err,
   output logic        stale
);

   localparam logic [7:0]  STABLE_L  = STABLE_CYC[7:0];
   localparam logic [19:0] TIMEOUT_L = TIMEOUT_CYC[19:0];

   typedef enum logic [1:0] {CHANGING, SETTLING, HELD} state_t;

   state_t          state, state_nx;
   logic [9:0]      sync1, sync2, prev;
   logic [7:0]      cnt, cnt_nx, cnt_inc;
   logic            same, commit, legal;
   logic [1:0]      slot;
   logic [3:0]      smp_an, smp_hex;
   logic            smp_p, smp_le;
   logic [3:0][3:0] shadow_hex;
   logic [3:0]      shadow_p, shadow_le;
   logic [3:0]      seen, seen_nx;
   logic [19:0]     tcnt, tcnt_inc;

   assign smp_an  = sync2[9:6];
   assign smp_hex = sync2[5:2];
   assign smp_p   = sync2[1];
   assign smp_le  = sync2[0];
   assign same    = (sync2 == prev);
   assign cnt_inc = cnt + 8'd1;
   assign tcnt_inc = (tcnt == '1) ? tcnt : tcnt + 20'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
      end else begin
         sync1 <= {AN, Hex, p, LE};
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   always_comb begin
      legal = 1'b1;
      slot  = 2'd0;
      case (smp_an)
         4'b1110: slot = 2'd0;
         4'b1101: slot = 2'd1;
         4'b1011: slot = 2'd2;
         4'b0111: slot = 2'd3;
         default: legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= CHANGING;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Commit fires in the cycle the dwell count reaches STABLE_CYC, then HELD blocks repeats.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      commit   = 1'b0;
      case (state)
         CHANGING: begin
            cnt_nx = '0;
            if (same) begin
               if (STABLE_L == 8'd1) begin
                  commit   = 1'b1;
                  state_nx = HELD;
               end else begin
                  cnt_nx   = 8'd1;
                  state_nx = SETTLING;
               end
            end
         end
         SETTLING: begin
            if (!same) begin
               cnt_nx   = '0;
               state_nx = CHANGING;
            end else begin
               cnt_nx = cnt_inc;
               if (cnt_inc == STABLE_L) begin
                  commit   = 1'b1;
                  state_nx = HELD;
               end
            end
         end
         HELD: begin
            if (!same) begin
               cnt_nx   = '0;
               state_nx = CHANGING;
            end
         end
         default: begin
            cnt_nx   = '0;
            state_nx = CHANGING;
         end
      endcase
   end

   // A commit coinciding with a publish lands in the freshly cleared mask.
   always_comb begin
      seen_nx = (seen == 4'hF) ? 4'h0 : seen;
      if (commit && legal) seen_nx = seen_nx | ~smp_an;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_hex  <= '0;
         shadow_p    <= '0;
         shadow_le   <= '0;
         seen        <= '0;
         Hexs        <= '0;
         point       <= '0;
         LES         <= '0;
         frame_valid <= 1'b0;
         an_err      <= 1'b0;
         tcnt        <= '0;
         stale       <= 1'b0;
      end else begin
         seen        <= seen_nx;
         frame_valid <= 1'b0;
         if (seen == 4'hF) begin
            Hexs        <= shadow_hex;
            point       <= shadow_p;
            LES         <= shadow_le;
            frame_valid <= 1'b1;
         end
         if (commit && legal) begin
            shadow_hex[slot] <= smp_hex;
            shadow_p[slot]   <= smp_p;
            shadow_le[slot]  <= smp_le;
            tcnt             <= '0;
            stale            <= 1'b0;
         end else begin
            tcnt  <= tcnt_inc;
            stale <= (tcnt_inc >= TIMEOUT_L);
         end
         if (commit && !legal) an_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_disp_capture.sv
// Scoreboard bench for disp_capture: expected frames are queued with the stimulus and
// checked by an independent monitor whenever frame_valid pulses.
module tb_disp_capture;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  Hex;
   logic        p;
   logic        LE;
   logic [3:0]  AN;
   logic [15:0] Hexs;
   logic [3:0]  point;
   logic [3:0]  LES;
   logic        frame_valid;
   logic        an_err;
   logic        stale;

   typedef struct packed {
      logic [15:0] h;
      logic [3:0]  pt;
      logic [3:0]  le;
   } frame_t;

   frame_t exp_q[$];
   int     total = 0;
   int     bad   = 0;

   always #5 clk = ~clk;

   disp_capture #(.STABLE_CYC(4), .TIMEOUT_CYC(100)) dut (
      .clk(clk), .rst_n(rst_n), .Hex(Hex), .p(p), .LE(LE), .AN(AN),
      .Hexs(Hexs), .point(point), .LES(LES),
      .frame_valid(frame_valid), .an_err(an_err), .stale(stale)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every frame_valid pulse must match the oldest queued frame.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && frame_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_frame: got Hexs=%h point=%b LES=%b expected none", Hexs, point, LES);
         end else begin
            frame_t f;
            f = exp_q.pop_front();
            check("frame_hexs",  {16'h0, Hexs},  {16'h0, f.h});
            check("frame_point", {28'h0, point}, {28'h0, f.pt});
            check("frame_les",   {28'h0, LES},   {28'h0, f.le});
         end
      end
   end

   task automatic dwell(input logic [3:0] an, input logic [3:0] hx, input logic pp,
                        input logic le, input int n);
      AN = an; Hex = hx; p = pp; LE = le;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic digit(input int k, input logic [3:0] hx, input logic pp, input logic le);
      logic [3:0] an;
      an = ~(4'b0001 << k);
      dwell(an, hx, pp, le, 16);
   endtask

   task automatic scan(input logic [15:0] w, input logic [3:0] pts, input logic [3:0] les);
      for (int k = 0; k < 4; k++) digit(k, w[4*k +: 4], pts[k], les[k]);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s: got %0d frames pending expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      rst_n = 1'b0;
      AN = 4'b1110; Hex = 4'h0; p = 1'b0; LE = 1'b0;
      #21;
      check("rst_hexs",  {16'h0, Hexs},  32'h0);
      check("rst_point", {28'h0, point}, 32'h0);
      check("rst_les",   {28'h0, LES},   32'h0);
      check("rst_fv",    {31'h0, frame_valid}, 32'h0);
      check("rst_an_err",{31'h0, an_err}, 32'h0);
      check("rst_stale", {31'h0, stale},  32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // ordered scan
      exp_q.push_back('{16'h1234, 4'b0101, 4'b0011});
      scan(16'h1234, 4'b0101, 4'b0011);
      drain("ordered_drain");
      check("ordered_an_err", {31'h0, an_err}, 32'h0);

      // reverse order with digit 2 repeated, latest value wins
      exp_q.push_back('{16'h5B67, 4'b1101, 4'b0101});
      digit(3, 4'h5, 1'b1, 1'b0);
      digit(2, 4'hA, 1'b0, 1'b1);
      digit(2, 4'hB, 1'b1, 1'b1);
      digit(1, 4'h6, 1'b0, 1'b0);
      digit(0, 4'h7, 1'b1, 1'b1);
      drain("reverse_drain");

      // short glitch dwells between digits are ignored
      exp_q.push_back('{16'h1234, 4'b0101, 4'b0011});
      for (int k = 0; k < 4; k++) begin
         logic [15:0] w;
         logic [3:0]  pts, les;
         w = 16'h1234; pts = 4'b0101; les = 4'b0011;
         digit(k, w[4*k +: 4], pts[k], les[k]);
         if (k < 3) dwell(4'b1101, 4'hF, 1'b1, 1'b1, 2);
      end
      drain("glitch_drain");

      // illegal AN patterns between legal digits
      check("pre_illegal_an_err", {31'h0, an_err}, 32'h0);
      exp_q.push_back('{16'hCAFE, 4'b1010, 4'b1100});
      digit(0, 4'hE, 1'b0, 1'b0);
      digit(1, 4'hF, 1'b1, 1'b0);
      dwell(4'b1111, 4'hF, 1'b0, 1'b0, 16);
      check("illegal_all_off", {31'h0, an_err}, 32'h1);
      dwell(4'b1100, 4'hF, 1'b0, 1'b0, 16);
      check("illegal_two_on", {31'h0, an_err}, 32'h1);
      digit(2, 4'hA, 1'b0, 1'b1);
      digit(3, 4'hC, 1'b1, 1'b1);
      drain("illegal_drain");
      check("an_err_sticky", {31'h0, an_err}, 32'h1);

      // timeout with frozen illegal AN
      AN = 4'b1111; Hex = 4'hF; p = 1'b0; LE = 1'b0;
      check("stale_before", {31'h0, stale}, 32'h0);
      lat = 0;
      while (stale !== 1'b1 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      total++;
      if (lat < 86 || lat > 96) begin
         bad++;
         $display("FAIL stale_latency: got %0d cycles expected 86..96", lat);
      end
      check("stale_set", {31'h0, stale}, 32'h1);
      digit(0, 4'h1, 1'b0, 1'b0);
      check("stale_cleared", {31'h0, stale}, 32'h0);

      // async reset with three digits committed
      digit(1, 4'h2, 1'b0, 1'b0);
      digit(2, 4'h3, 1'b0, 1'b0);
      AN = 4'b0111; Hex = 4'h9; p = 1'b0; LE = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      check("async_hexs",  {16'h0, Hexs},  32'h0);
      check("async_point", {28'h0, point}, 32'h0);
      check("async_les",   {28'h0, LES},   32'h0);
      check("async_fv",    {31'h0, frame_valid}, 32'h0);
      check("async_an_err",{31'h0, an_err}, 32'h0);
      check("async_stale", {31'h0, stale},  32'h0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      exp_q.push_back('{16'h9E3D, 4'b0110, 4'b0001});
      scan(16'h9E3D, 4'b0110, 4'b0001);
      drain("post_reset_drain");
      check("post_reset_an_err", {31'h0, an_err}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
